// File: rtl/obi_instr_mem_responder.sv
// ---------------------------------------------------------------------------
// obi_instr_mem_responder
//
// Slave end of the prefetch buffer's OBI instruction bus. The block grants
// requests and returns word data in order after a fixed latency. Accesses
// beyond the memory depth come back with err=1 and zero data. A backdoor
// port preloads the program image.
//
// Parameters
//   MEM_WORDS        memory depth in 32-bit words (power of 2, <= 2**29)
//   RESP_LATENCY     cycles from grant to rvalid (1..8)
//   MAX_OUTSTANDING  max granted-but-unanswered transactions (1..8)
//
// Ports
//   clk, rst_n       clock (rising edge), async active-low reset
//   instr_req_i      OBI request
//   instr_addr_i     byte address; bits [1:0] ignored
//   instr_gnt_o      OBI grant, combinational from req and state
//   instr_rvalid_o   one-cycle response pulse per grant
//   instr_rdata_o    read data while rvalid=1, otherwise 0
//   instr_err_o      bus error while rvalid=1, otherwise 0
//   load_we_i        backdoor write enable
//   load_addr_i      backdoor word index (not a byte address)
//   load_wdata_i     backdoor write data
//
// Configuration
//   INSTR_MEM_GNT_STALL_EN  when defined, a 16-bit LFSR suppresses about 25%
//                           of grants in a pattern that is deterministic
//                           from reset. When undefined, grants never stall.
// ---------------------------------------------------------------------------
module obi_instr_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // One delay-line slot. Data and err are zero whenever valid is zero.
    // The output pins can therefore be driven straight from the last stage.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic [31:0]   mem [MEM_WORDS];
    resp_t         stage_q [RESP_LATENCY];
    resp_t         stage_d [RESP_LATENCY];
    logic [CW-1:0] cnt_q, cnt_d;

    logic          stall;
    logic          gnt;
    logic [AW-1:0] rd_idx;
    logic          rd_in_range;
    logic [AW-1:0] ld_idx;
    logic          ld_in_range;
    resp_t         rsp;

    // Byte-offset bits carry no information for word fetches.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^instr_addr_i[1:0];

    // ------------------------------------------------------------------
    // Optional grant stall source
    // ------------------------------------------------------------------
`ifdef INSTR_MEM_GNT_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR with taps 16,14,13,11 (bits 15,13,12,10).
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // A word index is in range exactly when all bits above the index width are zero.
    assign rd_idx      = instr_addr_i[AW+1:2];
    assign rd_in_range = (instr_addr_i[31:AW+2] == '0);
    assign ld_idx      = load_addr_i[AW-1:0];
    assign ld_in_range = (load_addr_i[31:AW] == '0);

    // Holding rst_n low keeps the grant low, even though the grant is combinational.
    assign gnt         = rst_n && instr_req_i && (cnt_q < MAX_CNT) && !stall;
    assign instr_gnt_o = gnt;

    assign rsp            = stage_q[RESP_LATENCY-1];
    assign instr_rvalid_o = rsp.valid;
    assign instr_err_o    = rsp.err;
    assign instr_rdata_o  = rsp.data;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default assignment first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        for (int i = 0; i < int'(RESP_LATENCY); i++) begin
            stage_d[i] = '0;
        end
        cnt_d = cnt_q;

        // The memory is read in the grant cycle, before the same edge's
        // backdoor write lands, so a colliding write is seen by the next read only.
        stage_d[0].valid = gnt;
        stage_d[0].err   = gnt && !rd_in_range;
        stage_d[0].data  = (gnt && rd_in_range) ? mem[rd_idx] : 32'h0;
        for (int i = 1; i < int'(RESP_LATENCY); i++) begin
            stage_d[i] = stage_q[i-1];
        end

        // A grant and a response in the same cycle leave the count unchanged.
        case ({gnt, rsp.valid})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample their inputs from before the edge, whatever the order of the
    // statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RESP_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(RESP_LATENCY); i++) begin
                stage_q[i] <= stage_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the memory array has no reset. The preloaded program image must
    // survive a reset, and a reset branch would also stop the array from
    // mapping onto RAM.
    always_ff @(posedge clk) begin
        if (load_we_i && ld_in_range) begin
            mem[ld_idx] <= load_wdata_i;
        end
    end

endmodule
